// File: rtl/sym_dn_lut_loader.sv
// rtl/sym_dn_lut_loader.sv - write-side loader for the symmetric decision-node LUT rank
//
// Takes one LUT table (PAGE_NUM one-bit entries) as WORD_W-bit words over a
// valid/ready handshake. Each word is unpacked LSB first and written one entry
// per cycle, identically to both replicates of the rank.
//
// Ports:
//   write_clk                      in   sole clock, rising edge
//   rst                            in   synchronous reset, active-high
//   load_start                     in   1-cycle pulse, begin loading a new table (IDLE only)
//   lut_word_in[WORD_W]            in   packed LUT bits, bit i -> entry word_idx*WORD_W + i
//   lut_word_valid                 in   lut_word_in valid
//   lut_word_ready                 out  loader accepts lut_word_in this cycle
//   lut_in_bank0_replicate_0/1     out  write data (replicates identical)
//   page_write_addr_replicate_0/1  out  write address (replicates identical)
//   write_addr_offset_replicate_0/1 out deprecated, tied to 0
//   we                             out  write enable to the LUT rank
//   load_busy                      out  table load in progress
//   load_done                      out  1-cycle pulse, full table written

module sym_dn_lut_loader #(
    parameter int PAGE_NUM = 32,
    parameter int ADDR_W   = 5,
    parameter int WORD_W   = 8
) (
    input  logic              write_clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [WORD_W-1:0] lut_word_in,
    input  logic              lut_word_valid,
    output logic              lut_word_ready,
    output logic              lut_in_bank0_replicate_0,
    output logic [ADDR_W-1:0] page_write_addr_replicate_0,
    output logic              write_addr_offset_replicate_0,
    output logic              lut_in_bank0_replicate_1,
    output logic [ADDR_W-1:0] page_write_addr_replicate_1,
    output logic              write_addr_offset_replicate_1,
    output logic              we,
    output logic              load_busy,
    output logic              load_done
);

    localparam int NUM_WORDS = PAGE_NUM / WORD_W;
    localparam int CNT_W     = $clog2(WORD_W + 1);
    localparam int WCNT_W    = $clog2(NUM_WORDS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [WORD_W-1:0]   r_sr;          // bits of the current word not yet written
    logic [CNT_W-1:0]    r_bits_left;   // valid bits remaining in r_sr
    logic [WCNT_W-1:0]   r_words;       // words accepted for this table
    logic [ADDR_W-1:0]   r_ptr;         // address of the next write
    logic [ADDR_W-1:0]   r_addr;
    logic                r_data;
    logic                r_we;
    logic                r_ready;
    logic                r_busy;
    logic                r_done;

    logic                w_accept;
    logic                w_shift;
    logic                w_write;
    logic                w_last_write;
    logic [CNT_W-1:0]    w_bits_left_nxt;
    logic [WCNT_W-1:0]   w_words_nxt;
    logic                w_ready_nxt;

    // r_ready is only ever set in LOAD, so it already qualifies the accept.
    assign w_accept = lut_word_valid & r_ready;

    // Ready implies an empty shift register, so accept and shift never overlap.
    assign w_shift = (r_state == S_LOAD) && (r_bits_left != '0);
    assign w_write = w_accept | w_shift;

    // The entry at the top address is on the write port this cycle.
    assign w_last_write = r_we && (r_addr == ADDR_W'(PAGE_NUM - 1));

    always_comb begin
        w_bits_left_nxt = r_bits_left;
        w_words_nxt     = r_words;
        if (w_accept) begin
            // Bit 0 leaves immediately for the write port; the rest wait here.
            w_bits_left_nxt = CNT_W'(WORD_W - 1);
            w_words_nxt     = r_words + WCNT_W'(1);
        end else if (w_shift) begin
            w_bits_left_nxt = r_bits_left - CNT_W'(1);
        end
    end

    // Ready is registered: it is computed for the next cycle from the next
    // shift-register occupancy. An empty register on the next cycle means the
    // last bit of the current word is on the write port then, which keeps
    // back-to-back words gapless.
    assign w_ready_nxt = (w_bits_left_nxt == '0) && (w_words_nxt < WCNT_W'(NUM_WORDS));

    always_ff @(posedge write_clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sr        <= '0;
            r_bits_left <= '0;
            r_words     <= '0;
            r_ptr       <= '0;
            r_addr      <= '0;
            r_data      <= 1'b0;
            r_we        <= 1'b0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_we    <= 1'b0;
                    r_done  <= 1'b0;
                    r_ready <= 1'b0;
                    if (load_start) begin
                        r_state     <= S_LOAD;
                        r_busy      <= 1'b1;
                        r_ready     <= 1'b1;
                        r_words     <= '0;
                        r_bits_left <= '0;
                        r_ptr       <= '0;
                    end
                end

                S_LOAD: begin
                    // load_start is deliberately not looked at here.
                    r_we        <= w_write;
                    r_bits_left <= w_bits_left_nxt;
                    r_words     <= w_words_nxt;
                    if (w_write) begin
                        r_addr <= r_ptr;
                        // r_ptr wraps to 0 after the top entry since 2**ADDR_W == PAGE_NUM.
                        r_ptr  <= r_ptr + ADDR_W'(1);
                        r_data <= w_accept ? lut_word_in[0] : r_sr[0];
                    end
                    if (w_accept) begin
                        r_sr <= lut_word_in >> 1;
                    end else if (w_shift) begin
                        r_sr <= r_sr >> 1;
                    end
                    // Address and data hold through valid gaps (r_we drops).
                    if (w_last_write) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_ready <= 1'b0;
                    end else begin
                        r_ready <= w_ready_nxt;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_we    <= 1'b0;
                    r_ready <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign lut_word_ready                = r_ready;
    assign lut_in_bank0_replicate_0      = r_data;
    assign page_write_addr_replicate_0   = r_addr;
    assign write_addr_offset_replicate_0 = 1'b0;
    assign lut_in_bank0_replicate_1      = r_data;
    assign page_write_addr_replicate_1   = r_addr;
    assign write_addr_offset_replicate_1 = 1'b0;
    assign we                            = r_we;
    assign load_busy                     = r_busy;
    assign load_done                     = r_done;

endmodule

// File: tb/tb_sym_dn_lut_loader.sv
// tb/tb_sym_dn_lut_loader.sv - scoreboard bench for sym_dn_lut_loader

module tb_sym_dn_lut_loader;

    localparam int PAGE_NUM = 32;
    localparam int ADDR_W   = 5;
    localparam int WORD_W   = 8;
    localparam int NW       = PAGE_NUM / WORD_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_start;
    logic [WORD_W-1:0] lut_word_in;
    logic              lut_word_valid;
    logic              lut_word_ready;
    logic              d0, d1, o0, o1;
    logic [ADDR_W-1:0] a0, a1;
    logic              we, load_busy, load_done;

    sym_dn_lut_loader #(.PAGE_NUM(PAGE_NUM), .ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
        .write_clk                     (clk),
        .rst                           (rst),
        .load_start                    (load_start),
        .lut_word_in                   (lut_word_in),
        .lut_word_valid                (lut_word_valid),
        .lut_word_ready                (lut_word_ready),
        .lut_in_bank0_replicate_0      (d0),
        .page_write_addr_replicate_0   (a0),
        .write_addr_offset_replicate_0 (o0),
        .lut_in_bank0_replicate_1      (d1),
        .page_write_addr_replicate_1   (a1),
        .write_addr_offset_replicate_1 (o1),
        .we                            (we),
        .load_busy                     (load_busy),
        .load_done                     (load_done)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];

    // Per-load observations gathered by the monitor.
    int done_seen  = 0;
    int done_cyc   = 0;
    int first_we   = 0;
    int gap_cyc    = 0;
    int busy_cyc   = 0;
    bit seen_we    = 0;
    int last_addr  = 0;
    int last_data  = 0;

    int  gaps[NW];
    bit  abort = 0;

    // A reset discards every write still expected from the aborted table.
    always @(posedge clk) if (rst) exp_q.delete();

    always @(negedge clk) begin
        if (!rst) begin
            if (load_start && !load_busy && !load_done) begin
                seen_we  = 0;
                gap_cyc  = 0;
                busy_cyc = 0;
            end
            check("replicate_match", {d1, a1}, {d0, a0});
            check("offsets_zero", {o0, o1}, 0);
            if (load_busy) busy_cyc++;
            if (we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write_addr", a0, -1);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("write_addr", a0, e.addr);
                    check("write_data", d0, e.data);
                end
                if (!seen_we) first_we = cyc;
                seen_we   = 1;
                last_addr = a0;
                last_data = d0;
            end else if (load_busy && seen_we) begin
                gap_cyc++;
                check("gap_addr_hold", a0, last_addr);
                check("gap_data_hold", d0, last_data);
            end
            if (load_done) begin
                done_seen++;
                done_cyc = cyc;
                check("done_all_written", exp_q.size(), 0);
            end
        end
    end

    task automatic start_load(input logic [PAGE_NUM-1:0] tbl, output int start_cyc);
        @(posedge clk); #1;
        load_start = 1'b1;
        start_cyc  = cyc;
        for (int n = 0; n < PAGE_NUM; n++) exp_q.push_back('{n, int'(tbl[n])});
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    // gap = number of cycles the word is held back after it could first be taken.
    task automatic send_word(input logic [WORD_W-1:0] w, input int gap, output bit ok);
        bit rdy;
        ok  = 0;
        rdy = 0;
        if (abort) return;
        if (gap > 0) begin
            for (int i = 0; i < 40 && !rdy && !abort; i++) begin
                @(negedge clk);
                if (lut_word_ready) rdy = 1;
                else begin @(posedge clk); #1; end
            end
            if (!rdy) return;
            @(posedge clk); #1;
            repeat (gap - 1) begin @(posedge clk); #1; end
        end
        lut_word_valid = 1'b1;
        lut_word_in    = w;
        for (int i = 0; i < 40 && !ok && !abort; i++) begin
            @(negedge clk);
            if (lut_word_ready && !rst) ok = 1;
            @(posedge clk); #1;
        end
        lut_word_valid = 1'b0;
    endtask

    // mode: 0 plain, 1 extra load_start at addr 10, 2 reset at addr 17, 3 fifth word offered
    task automatic do_load(input logic [PAGE_NUM-1:0] tbl, input int mode);
        int start_cyc, d_before, gsum;
        d_before = done_seen;
        gsum     = 0;
        for (int i = 0; i < NW; i++) gsum += gaps[i];
        abort = 0;
        start_load(tbl, start_cyc);
        fork
            begin
                bit ok;
                for (int w = 0; w < NW; w++) begin
                    send_word(tbl[w*WORD_W +: WORD_W], gaps[w], ok);
                    if (!abort) check("word_accepted", int'(ok), 1);
                end
                if (mode == 3) begin
                    lut_word_valid = 1'b1;
                    lut_word_in    = 8'h5A;
                    for (int i = 0; i < 45; i++) begin
                        @(negedge clk);
                        check("ready_after_last_word", lut_word_ready, 0);
                    end
                    lut_word_valid = 1'b0;
                end
            end
            begin
                if (mode == 1 || mode == 2) begin
                    bit hit;
                    hit = 0;
                    for (int i = 0; i < 200 && !hit; i++) begin
                        @(negedge clk);
                        if (we && int'(a0) == ((mode == 1) ? 10 : 17)) hit = 1;
                    end
                    check("inject_point_reached", int'(hit), 1);
                    if (mode == 1) begin
                        load_start = 1'b1;
                        @(posedge clk); #1;
                        load_start = 1'b0;
                    end else begin
                        rst   = 1'b1;
                        abort = 1;
                        @(posedge clk); #1;
                        rst = 1'b0;
                        @(negedge clk);
                        check("rst_we", we, 0);
                        check("rst_busy", load_busy, 0);
                        check("rst_done", load_done, 0);
                        check("rst_ready", lut_word_ready, 0);
                    end
                end
            end
        join
        if (mode == 2) begin
            repeat (10) @(posedge clk);
            check("rst_no_done", done_seen, d_before);
            abort = 0;
        end else begin
            for (int i = 0; i < 300 && done_seen == d_before; i++) @(posedge clk);
            repeat (5) @(posedge clk);
            check("done_count", done_seen, d_before + 1);
            check("done_cycle", done_cyc - start_cyc, PAGE_NUM + 2 + gsum);
            check("first_we_cycle", first_we - start_cyc, 2 + gaps[0]);
            check("we_gap_cycles", gap_cyc, gsum - gaps[0]);
            check("busy_cycles", busy_cyc, PAGE_NUM + 1 + gsum);
            check("writes_outstanding", exp_q.size(), 0);
        end
    endtask

    initial begin
        rst            = 1'b1;
        load_start     = 1'b0;
        lut_word_in    = '0;
        lut_word_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset_idle_outputs",
                  {we, lut_word_ready, load_busy, load_done, d0, a0, d1, a1, o0, o1}, 0);
        end

        // Fixed words A5,0F,FF,00 back to back.
        for (int i = 0; i < NW; i++) gaps[i] = 0;
        do_load({8'h00, 8'hFF, 8'h0F, 8'hA5}, 0);

        // Three-cycle valid gap between the first and second word.
        gaps[1] = 3;
        do_load($urandom, 0);
        gaps[1] = 0;

        // Extra load_start mid-table is ignored.
        do_load($urandom, 1);

        // Reset in the middle of a table, then a fresh load from address 0.
        do_load($urandom, 2);
        do_load($urandom, 0);

        // A fifth word is never taken.
        do_load($urandom, 3);

        // Random tables with random valid gaps.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < NW; i++) gaps[i] = $urandom_range(0, 3);
            do_load($urandom, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=finished", cyc);
        $fatal(1, "timeout");
    end

endmodule
